// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM interface types and constants for the cache-control path.
// Includes the arbiter state enum and the load value returned on failed accesses.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT
    } arb_state_t;

    localparam word_t BADWORD = 32'hBAD1BAD1;

endpackage

// File: rtl/ram_arbiter.sv
// Arbitrates instruction and data cache requests onto one RAM port.
// Data has priority; instruction is forced after STARVE data grants while it waits.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE  = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter word_t       BADWORD = cpu_types_pkg::BADWORD
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    localparam logic [2:0] StarveMax   = 3'(STARVE);
    localparam logic [6:0] TimeoutLast = 7'(TIMEOUT - 1);

    arb_state_t state_q;
    logic [2:0] dcount_q;
    logic [6:0] tcount_q;
    logic       err_q;

    logic d_req;
    logic req_held;
    logic done_ok;
    logic done_bad;
    logic done;

    // A grant only completes while its request is still held; a withdrawn
    // request aborts silently.
    always_comb begin
        d_req    = dREN | dWEN;
        req_held = 1'b0;
        if (state_q == DGRANT) begin
            req_held = d_req;
        end else if (state_q == IGRANT) begin
            req_held = iREN;
        end
        done_ok  = req_held && (ramstate == ACCESS);
        done_bad = req_held && !done_ok
                   && ((ramstate == ERROR) || (tcount_q == TimeoutLast));
        done     = done_ok | done_bad;
    end

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~done;
                if (done_ok) begin
                    dload = ramload;
                end else if (done_bad) begin
                    dload = BADWORD;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                iwait   = ~done;
                if (done_ok) begin
                    iload = ramload;
                end else if (done_bad) begin
                    iload = BADWORD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            dcount_q <= '0;
            tcount_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tcount_q <= '0;
                    if (d_req && !(iREN && (dcount_q == StarveMax))) begin
                        state_q <= DGRANT;
                    end else if (iREN) begin
                        state_q <= IGRANT;
                    end
                end
                DGRANT, IGRANT: begin
                    tcount_q <= tcount_q + 7'd1;
                    if (!req_held || done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (done_bad) begin
                err_q <= 1'b1;
            end
            // Streak of data completions seen while an instruction fetch waits.
            if (done) begin
                if ((state_q == IGRANT) || !iREN) begin
                    dcount_q <= '0;
                end else if (dcount_q != StarveMax) begin
                    dcount_q <= dcount_q + 3'd1;
                end
            end
        end
    end

    assign err = err_q;

endmodule
